// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and scoreboard types, used by the decoder-side hazard logic.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int SB_CNT_W   = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/drain handshake between the pipeline (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if;
    import pipeline_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_reg_write;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  drain_req;
    logic                  issue_stall;
    logic                  pc_hold;
    logic                  issue_fire;
    logic                  drain_done;
    logic                  busy_any;
    logic                  err_underflow;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
        output wb_valid, wb_addr, drain_req,
        input  issue_stall, pc_hold, issue_fire, drain_done, busy_any, err_underflow
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
        input  wb_valid, wb_addr, drain_req,
        output issue_stall, pc_hold, issue_fire, drain_done, busy_any, err_underflow
    );

endinterface

// File: rtl/hazard_scoreboard_reg_pending_counter.sv
// Saturating pending-write counter for one architectural register.
module reg_pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic underflow,
    output logic eff_nz,
    output logic nz_next
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_eff = cnt;
        if (dec && cnt != '0) cnt_eff = cnt - CNT_W'(1);
        cnt_nxt = cnt;
        case ({inc, dec})
            2'b10:   cnt_nxt = full ? cnt : cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt_eff;
            default: cnt_nxt = cnt;
        endcase
    end

    assign full      = &cnt;
    assign underflow = dec && (cnt == '0);
    assign eff_nz    = (cnt_eff != '0);
    assign nz_next   = (cnt_nxt != '0);

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register pending counters, decode stall and drain FSM.
module hazard_scoreboard #(
    parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
    parameter int CNT_W    = pipeline_pkg::SB_CNT_W
) (
    input logic           clk,
    input logic           reset,
    hazard_scoreboard_if.slave sb
);
    import pipeline_pkg::*;

    sb_state_e           state;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] uf;
    logic [NUM_REGS-1:0] eff_nz;
    logic [NUM_REGS-1:0] nz_next;
    logic                rs_hit;
    logic                rt_hit;
    logic                dest_full;
    logic                stall;
    logic                fire;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    // Register 0 is hardwired zero: never tracked, never busy.
    assign inc[0]     = 1'b0;
    assign dec[0]     = 1'b0;
    assign full[0]    = 1'b0;
    assign uf[0]      = 1'b0;
    assign eff_nz[0]  = 1'b0;
    assign nz_next[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        assign inc[r] = fire && sb.id_reg_write && (sb.id_dest == REG_ADDR_W'(r));
        assign dec[r] = sb.wb_valid && (sb.wb_addr == REG_ADDR_W'(r));

        reg_pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .full      (full[r]),
            .underflow (uf[r]),
            .eff_nz    (eff_nz[r]),
            .nz_next   (nz_next[r])
        );
    end

    // Sources see the same-cycle writeback; the destination limit uses the raw count.
    assign rs_hit    = sb.id_uses_rs && eff_nz[sb.id_rs];
    assign rt_hit    = sb.id_uses_rt && eff_nz[sb.id_rt];
    assign dest_full = sb.id_reg_write && (sb.id_dest != '0) && full[sb.id_dest];
    assign stall     = sb.id_valid && (rs_hit || rt_hit || dest_full || (state != RUN));
    assign fire      = sb.id_valid && !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RUN;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= |nz_next;
            err_q  <= err_q | (|uf);
            done_q <= 1'b0;
            case (state)
                RUN:   if (sb.drain_req) state <= DRAIN;
                DRAIN: if (!(|nz_next)) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE:  state <= sb.drain_req ? HOLD : RUN;
                HOLD:  if (!sb.drain_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign sb.issue_stall   = stall;
    assign sb.pc_hold       = stall;
    assign sb.issue_fire    = fire;
    assign sb.drain_done    = done_q;
    assign sb.busy_any      = busy_q;
    assign sb.err_underflow = err_q;

endmodule
